// File: rtl/user_counter_bank_pkg.sv
// rtl/user_counter_bank_pkg.sv - register map, CTRL bit positions and byte-lane merge helper
`timescale 1ns/1ps
package user_counter_bank_pkg;

  // Register offsets within one channel window
  localparam logic [3:0] COUNT_OFF = 4'h0;
  localparam logic [3:0] CTRL_OFF  = 4'h4;
  localparam logic [3:0] CMP_OFF   = 4'h8;
  localparam logic [3:0] STAT_OFF  = 4'hC;

  // CTRL bit indices
  localparam int CTRL_EN      = 0;
  localparam int CTRL_DOWN    = 1;
  localparam int CTRL_RELOAD  = 2;
  localparam int CTRL_IRQ_EN  = 3;
  localparam int CTRL_PSC_LSB = 8;

  // Address distance between consecutive channels
  localparam int CH_STRIDE = 16;

  // Replace only the byte lanes whose select bit is set
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = sel[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/user_counter_channel.sv
// rtl/user_counter_channel.sv - one counter channel; prescaler built only with USER_COUNTER_PRESCALE_EN
`timescale 1ns/1ps
module user_counter_channel
  import user_counter_bank_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [3:0]       reg_off,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_sel,
  input  logic [WIDTH-1:0] la_mask,
  input  logic [WIDTH-1:0] la_data,
  output logic [31:0]      rd_data,
  output logic [WIDTH-1:0] count,
  output logic             irq_req
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] cmp_q;
  logic [3:0]       ctrl_q;
  logic             match_q;
  logic [7:0]       psc_val;

  logic [31:0]      wmerge;
  logic [WIDTH-1:0] count_next;
  logic             count_wr;
  logic             stat_clr;
  logic             tick;
  logic             adv;
  logic             la_active;
  logic             cond;
  logic             match_evt;
  logic             down;

  assign down      = ctrl_q[CTRL_DOWN];
  assign count_wr  = wr_en && (reg_off == COUNT_OFF);
  assign stat_clr  = wr_en && (reg_off == STAT_OFF) && wr_sel[0] && wr_data[0];
  assign la_active = |la_mask;

`ifdef USER_COUNTER_PRESCALE_EN
  logic [7:0] psc_q;
  logic [7:0] psc_cnt_q;

  assign psc_val = psc_q;
  assign tick    = ctrl_q[CTRL_EN] && (psc_cnt_q == psc_q);

  // Prescale divider: restarts on COUNT writes and while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_cnt_q <= 8'h0;
    end else if (!ctrl_q[CTRL_EN] || count_wr) begin
      psc_cnt_q <= 8'h0;
    end else if (tick) begin
      psc_cnt_q <= 8'h0;
    end else begin
      psc_cnt_q <= psc_cnt_q + 8'h1;
    end
  end

  // Prescale field of CTRL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q <= 8'h0;
    end else if (wr_en && (reg_off == CTRL_OFF)) begin
      psc_q <= wmerge[CTRL_PSC_LSB +: 8];
    end
  end
`else
  assign psc_val = 8'h0;
  assign tick    = ctrl_q[CTRL_EN];
`endif

  // A write to this channel or an LA preload swallows the tick for this cycle
  assign adv       = tick && !wr_en && !la_active;
  assign cond      = down ? (count_q == '0) : (count_q == cmp_q);
  assign match_evt = adv && cond;

  // Register read view, zero-extended; also the base for byte-lane writes
  always_comb begin
    rd_data = 32'h0;
    case (reg_off)
      COUNT_OFF: rd_data = 32'(count_q);
      CTRL_OFF:  rd_data = {16'h0, psc_val, 4'h0, ctrl_q};
      CMP_OFF:   rd_data = 32'(cmp_q);
      STAT_OFF:  rd_data = {31'h0, match_q};
      default:   rd_data = 32'h0;
    endcase
  end

  assign wmerge = byte_merge(rd_data, wr_data, wr_sel);

  // COUNT next value: bus write, then LA preload, then tick step/reload
  always_comb begin
    count_next = count_q;
    if (count_wr) begin
      count_next = wmerge[WIDTH-1:0];
    end else if (la_active) begin
      count_next = (count_q & ~la_mask) | (la_data & la_mask);
    end else if (adv) begin
      if (cond && ctrl_q[CTRL_RELOAD]) begin
        count_next = down ? cmp_q : '0;
      end else begin
        count_next = down ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
      end
    end
  end

  // Counter, CTRL, COMPARE and MATCH state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      cmp_q   <= '0;
      ctrl_q  <= 4'h0;
      match_q <= 1'b0;
    end else begin
      count_q <= count_next;
      if (wr_en && (reg_off == CTRL_OFF)) ctrl_q <= wmerge[3:0];
      if (wr_en && (reg_off == CMP_OFF))  cmp_q  <= wmerge[WIDTH-1:0];
      match_q <= match_evt || (match_q && !stat_clr);
    end
  end

  assign count   = count_q;
  assign irq_req = match_q && ctrl_q[CTRL_IRQ_EN];

endmodule

// File: rtl/user_counter_bank.sv
// rtl/user_counter_bank.sv - Wishbone counter/timer bank top; optional USER_COUNTER_PRESCALE_EN prescalers
`timescale 1ns/1ps
module user_counter_bank
  import user_counter_bank_pkg::*;
#(
  parameter int          CHANNELS  = 4,
  parameter int          WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          IO_BITS   = 30
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic               wbs_stb_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_dat_i,
  input  logic [31:0]        wbs_adr_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  input  logic [31:0]        la_data_in,
  input  logic [31:0]        la_oenb,
  output logic [IO_BITS-1:0] io_out,
  output logic [IO_BITS-1:0] io_oeb,
  output logic [2:0]         user_irq
);

  logic               valid;
  logic               accept;
  logic               ack_q;
  logic [31:0]        dat_q;
  logic               irq_q;
  logic [31:0]        off;
  logic               in_range;
  logic [2:0]         ch_idx;
  logic [3:0]         reg_off;
  logic [31:0]        rd_mux;

  logic [31:0]        ch_rd    [CHANNELS];
  logic [WIDTH-1:0]   ch_count [CHANNELS];
  logic [CHANNELS-1:0] ch_irq;

  // The cycle after an ack never accepts, so accesses complete one per two cycles
  assign valid    = wbs_cyc_i && wbs_stb_i;
  assign accept   = valid && !ack_q;
  assign off      = wbs_adr_i - BASE_ADDR;
  assign in_range = off < 32'(CHANNELS * CH_STRIDE);
  assign ch_idx   = off[6:4];
  assign reg_off  = {off[3:2], 2'b00};

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic             wr_en;
    logic [WIDTH-1:0] la_mask;

    assign wr_en = accept && wbs_we_i && in_range && (ch_idx == 3'(c));

    if (c == 0) begin : g_la
      assign la_mask = ~la_oenb[WIDTH-1:0] & {WIDTH{!valid}};
    end else begin : g_no_la
      assign la_mask = '0;
    end

    user_counter_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk     (wb_clk_i),
      .rst_n   (wb_rst_ni),
      .wr_en   (wr_en),
      .reg_off (reg_off),
      .wr_data (wbs_dat_i),
      .wr_sel  (wbs_sel_i),
      .la_mask (la_mask),
      .la_data (la_data_in[WIDTH-1:0]),
      .rd_data (ch_rd[c]),
      .count   (ch_count[c]),
      .irq_req (ch_irq[c])
    );
  end

  // Read mux: addressed channel's register, zero for unmapped addresses
  always_comb begin
    rd_mux = 32'h0;
    if (in_range) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (ch_idx == 3'(c)) rd_mux = ch_rd[c];
      end
    end
  end

  // Ack pulse and registered read data
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q <= 1'b0;
      dat_q <= 32'h0;
    end else begin
      ack_q <= accept;
      dat_q <= (accept && !wbs_we_i) ? rd_mux : 32'h0;
    end
  end

  // Merged, registered interrupt
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |ch_irq;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign io_out    = IO_BITS'(ch_count[0]);
  assign io_oeb    = '0;
  assign user_irq  = {2'b00, irq_q};

endmodule

// File: doc/user_counter_bank.md
# user_counter_bank

Multi-channel, Wishbone-mapped counter/timer bank for the user project area; the parametrised successor of the single free-running counter. Each of `CHANNELS` counters has its own width-limited count, direction, compare value, auto-reload and interrupt flag. Channel 0 keeps the Logic Analyzer preload path and drives the user IO pads. Match flags are merged onto `user_irq[0]`.

## Interface
Parameters:
- `CHANNELS`, 4: number of counter channels, 1..8.
- `WIDTH`, 32: counter width in bits, 8..32.
- `BASE_ADDR`, 32'h3000_0000: Wishbone base address. Channel n occupies `BASE_ADDR + n*0x10`.
- `IO_BITS`, 30: number of low count bits of channel 0 driven to `io_out`.

Ports:
- `wb_clk_i`  in  1: single clock for all logic.
- `wb_rst_ni`  in  1: asynchronous, active-low reset.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1 each: Wishbone strobe, cycle and write-enable.
- `wbs_sel_i`  in  4: byte-lane selects.
- `wbs_dat_i`, `wbs_adr_i`  in  32 each: write data and address.
- `wbs_ack_o`  out  1: acknowledge.
- `wbs_dat_o`  out  32: read data.
- `la_data_in`  in  32: LA preload value for channel 0.
- `la_oenb`  in  32: per-bit LA preload enable, active-low.
- `io_out`  out  `IO_BITS`: channel 0 count bits `[IO_BITS-1:0]`.
- `io_oeb`  out  `IO_BITS`: tied to all-zero (pads are outputs).
- `user_irq`  out  3: bit 0 carries the merged interrupt; bits 2:1 are tied to 0.

## Operation
Per-channel registers, by offset from the channel base:
- `+0x0` COUNT, RW.
- `+0x4` CTRL, RW:
  - bit 0 EN
  - bit 1 DOWN
  - bit 2 RELOAD
  - bit 3 IRQ_EN
  - bits 15:8 PRESCALE (see Configuration)
- `+0x8` COMPARE, RW.
- `+0xC` STATUS, bit 0 MATCH; write 1 to clear.

Width and access rules:
- Writes honour `wbs_sel_i` per byte. Only the low `WIDTH` bits are stored.
- Reads are zero-extended to 32 bits.
- Any address outside the mapped range is acknowledged; reads return 0 and writes are ignored.

Counting, on each enabled tick:
- Up: COUNT+1. Down: COUNT-1.
- Arithmetic is modulo 2^`WIDTH`; wrap-around is silent.

Match and reload:
- Match condition: up when COUNT==COMPARE; down when COUNT==0. The condition is evaluated on the current value when a tick occurs.
- On match with RELOAD=1, the next value is 0 (up) or COMPARE (down), instead of the step.
- MATCH is set on every match event.

Interrupt:
- `user_irq[0]` = OR over all channels of (MATCH & IRQ_EN), registered.

LA preload on channel 0:
- Each bit i < `WIDTH` with `la_oenb[i]`=0 loads `la_data_in[i]` into COUNT bit i.
- It applies only in cycles with no valid Wishbone access.

Priority on COUNT, per cycle: Wishbone write > LA preload > tick.

Status flag events:
- A STATUS write-1-clear in the same cycle as a new match leaves MATCH set.
- Writing CTRL.EN=0 freezes COUNT but keeps MATCH.

Reset values (all registers and outputs 0):
- COUNT, CTRL, COMPARE, MATCH = 0.
- `wbs_ack_o`=0, `wbs_dat_o`=0, `user_irq`=0, `io_out`=0.

## Timing
- An access is valid when `wbs_cyc_i & wbs_stb_i`.
- `wbs_ack_o` pulses one cycle after the access is accepted. `wbs_dat_o` is valid in the ack cycle.
- After each ack, ack is forced low for one cycle. Sustained back-to-back accesses therefore complete one every 2 cycles.
- A write takes effect on the ack edge. The tick in that cycle is discarded for the written channel.
- `io_out` and COUNT reads show the register value with no extra latency.
- `user_irq[0]` rises 1 cycle after MATCH sets, and falls 1 cycle after MATCH clears.
- Reset assertion mid-transaction:
  - clears all state immediately;
  - drops any pending ack.
  - The master must retry the access.

## Configuration
- `USER_COUNTER_PRESCALE_EN` defined:
  - Each channel has an 8-bit prescaler.
  - An enabled tick occurs every PRESCALE+1 enabled cycles.
  - The prescaler resets to 0 on any COUNT write or when EN=0.
- Not defined:
  - CTRL[15:8] reads 0 and ignores writes.
  - Ticks occur every enabled cycle.
  - No prescaler flops are built.

## Structure
- Package `user_counter_bank_pkg`:
  - register offsets (`COUNT_OFF`, `CTRL_OFF`, `CMP_OFF`, `STAT_OFF`);
  - CTRL bit indices;
  - channel stride 0x10.
- Sub-module `user_counter_channel`:
  - one counter, COMPARE, CTRL, MATCH and prescaler;
  - instantiated `CHANNELS` times by generate.
- The top level contains:
  - Wishbone decode and ack;
  - the read mux;
  - LA muxing;
  - the IRQ OR.

## Test plan
- Reset, then write CTRL0=0x1 and hold 10 cycles → COUNT0 reads 10 (±1 access cycle); `io_out`=COUNT0[29:0].
- Channel 1: COMPARE=5, CTRL=0xD (EN, RELOAD, IRQ_EN) → COUNT sequence 0..5,0,…; MATCH=1; `user_irq[0]`=1 one cycle later. Writing STATUS=1 clears both.
- Channel 2: DOWN, COUNT=0x2, no RELOAD, `WIDTH`=32 → 2,1,0,0xFFFF_FFFF; MATCH sets at 0.
- Channel 0 with `la_oenb[7:0]`=0 and `la_data_in`=0xA5, no WB traffic → COUNT0[7:0]=0xA5 next cycle. With a simultaneous WB write of 0x10, COUNT0=0x10.
- WB byte write of 0xFF to COUNT3 with sel=4'b0010 → only bits 15:8 change. A read of an unmapped offset returns 0 with a single ack pulse.
- With `USER_COUNTER_PRESCALE_EN`: PRESCALE=3 and 12 enabled cycles → COUNT advances by 3.
